// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: datapath width, size encodings, FSM states.
package lsu_pkg;

  localparam int unsigned N          = 64;
  localparam int unsigned WORD_BYTES = 8;
  localparam int unsigned OFF_W      = 3;

  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;
  localparam logic [1:0] SIZE_D = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_WAIT,
    ST_WRITE,
    ST_RESP
  } state_e;

  // Right-justified byte mask covering an access of the given size.
  function automatic logic [N-1:0] size_mask(input logic [1:0] size);
    logic [N-1:0] m;
    case (size)
      SIZE_B:  m = N'(64'h0000_0000_0000_00FF);
      SIZE_H:  m = N'(64'h0000_0000_0000_FFFF);
      SIZE_W:  m = N'(64'h0000_0000_FFFF_FFFF);
      default: m = N'(64'hFFFF_FFFF_FFFF_FFFF);
    endcase
    return m;
  endfunction

endpackage

// File: rtl/byte_lane_align.sv
// Byte-lane steering for the LSU: load extract/extend, store merge, and alignment check.
module byte_lane_align
  import lsu_pkg::*;
(
  input  logic [1:0]       chk_size,
  input  logic [OFF_W-1:0] chk_offset,
  output logic             misaligned_c,
  input  logic [1:0]       size,
  input  logic             sign_ext,
  input  logic [OFF_W-1:0] offset,
  input  logic [N-1:0]     rdata,
  input  logic [N-1:0]     wdata,
  output logic [N-1:0]     load_data_c,
  output logic [N-1:0]     merge_data_c
);

  logic [5:0]   shamt;
  logic [N-1:0] lane;
  logic [N-1:0] mask;

  // Misaligned when any offset bit below the access size is set.
  always_comb begin
    misaligned_c = 1'b0;
    case (chk_size)
      SIZE_B:  misaligned_c = 1'b0;
      SIZE_H:  misaligned_c = chk_offset[0];
      SIZE_W:  misaligned_c = |chk_offset[1:0];
      default: misaligned_c = |chk_offset;
    endcase
  end

  always_comb begin
    shamt       = {offset, 3'b000};
    lane        = rdata >> shamt;
    load_data_c = lane;
    case (size)
      SIZE_B:  load_data_c = {{(N-8){sign_ext & lane[7]}}, lane[7:0]};
      SIZE_H:  load_data_c = {{(N-16){sign_ext & lane[15]}}, lane[15:0]};
      SIZE_W:  load_data_c = {{(N-32){sign_ext & lane[31]}}, lane[31:0]};
      default: load_data_c = lane;
    endcase
    // Little-endian merge: new bytes replace lane offset, the rest keep memory contents.
    mask         = size_mask(size) << shamt;
    merge_data_c = (rdata & ~mask) | ((wdata << shamt) & mask);
  end

endmodule

// File: rtl/load_store_unit.sv
// Data-memory initiator: one load/store at a time, sub-word stores via read-modify-write.
module load_store_unit
  import lsu_pkg::*;
(
  input  logic         clock,
  input  logic         reset_n,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic         req_write,
  input  logic [1:0]   req_size,
  input  logic         req_signed,
  input  logic [N-1:0] req_address,
  input  logic [N-1:0] req_wdata,
  output logic         resp_valid,
  output logic [N-1:0] resp_data,
  output logic         resp_fault,
  output logic         mem_read,
  output logic         mem_write,
  output logic [N-1:0] mem_address,
  output logic [N-1:0] mem_wdata,
  input  logic [N-1:0] mem_rdata
);

  state_e       state_q, state_d;
  logic [N-1:0] addr_q, addr_d;
  logic [1:0]   size_q, size_d;
  logic         sign_q, sign_d;
  logic         write_q, write_d;
  logic [N-1:0] wdata_q, wdata_d;
  logic [N-1:0] resp_data_q, resp_data_d;
  logic         resp_fault_q, resp_fault_d;
  logic [N-1:0] mem_wdata_q, mem_wdata_d;

  logic         misaligned_c;
  logic [N-1:0] load_data_c;
  logic [N-1:0] merge_data_c;

  byte_lane_align u_align (
    .chk_size     (req_size),
    .chk_offset   (req_address[OFF_W-1:0]),
    .misaligned_c (misaligned_c),
    .size         (size_q),
    .sign_ext     (sign_q),
    .offset       (addr_q[OFF_W-1:0]),
    .rdata        (mem_rdata),
    .wdata        (wdata_q),
    .load_data_c  (load_data_c),
    .merge_data_c (merge_data_c)
  );

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      addr_q       <= '0;
      size_q       <= '0;
      sign_q       <= 1'b0;
      write_q      <= 1'b0;
      wdata_q      <= '0;
      resp_data_q  <= '0;
      resp_fault_q <= 1'b0;
      mem_wdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      size_q       <= size_d;
      sign_q       <= sign_d;
      write_q      <= write_d;
      wdata_q      <= wdata_d;
      resp_data_q  <= resp_data_d;
      resp_fault_q <= resp_fault_d;
      mem_wdata_q  <= mem_wdata_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    size_d       = size_q;
    sign_d       = sign_q;
    write_d      = write_q;
    wdata_d      = wdata_q;
    resp_data_d  = resp_data_q;
    resp_fault_d = resp_fault_q;
    mem_wdata_d  = mem_wdata_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          addr_d       = req_address;
          size_d       = req_size;
          sign_d       = req_signed;
          write_d      = req_write;
          wdata_d      = req_wdata;
          resp_data_d  = '0;
          resp_fault_d = 1'b0;
          if (misaligned_c) begin
            resp_fault_d = 1'b1;
            state_d      = ST_RESP;
          end else if (req_write && (req_size == SIZE_D)) begin
            mem_wdata_d = req_wdata;
            state_d     = ST_WRITE;
          end else begin
            state_d = ST_READ;
          end
        end
      end
      ST_READ: state_d = ST_WAIT;
      // Read data arrives here: finish a load or build the merged store word.
      ST_WAIT: begin
        if (write_q) begin
          mem_wdata_d = merge_data_c;
          state_d     = ST_WRITE;
        end else begin
          resp_data_d = load_data_c;
          state_d     = ST_RESP;
        end
      end
      ST_WRITE: state_d = ST_RESP;
      ST_RESP:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  assign req_ready   = (state_q == ST_IDLE);
  assign mem_read    = (state_q == ST_READ);
  assign mem_write   = (state_q == ST_WRITE);
  assign resp_valid  = (state_q == ST_RESP);
  assign resp_data   = resp_data_q;
  assign resp_fault  = resp_fault_q;
  assign mem_address = {3'b000, addr_q[N-1:OFF_W]};
  assign mem_wdata   = mem_wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit with a small registered-read memory model.
module tb_load_store_unit;

  logic        clock;
  logic        reset_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [63:0] req_address;
  logic [63:0] req_wdata;
  logic        resp_valid;
  logic [63:0] resp_data;
  logic        resp_fault;
  logic        mem_read;
  logic        mem_write;
  logic [63:0] mem_address;
  logic [63:0] mem_wdata;
  logic [63:0] mem_rdata;

  logic [63:0] mem [0:15];
  int          write_count = 0;
  int          checks = 0;
  int          failures = 0;
  int          wc0;

  load_store_unit dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_write   (req_write),
    .req_size    (req_size),
    .req_signed  (req_signed),
    .req_address (req_address),
    .req_wdata   (req_wdata),
    .resp_valid  (resp_valid),
    .resp_data   (resp_data),
    .resp_fault  (resp_fault),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .mem_address (mem_address),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (mem_write) begin
      mem[mem_address[3:0]] <= mem_wdata;
      write_count <= write_count + 1;
    end
    if (mem_read) mem_rdata <= mem[mem_address[3:0]];
  end

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $display("FAIL %s observed=0x%h expected=0x%h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  // Called at a negedge in IDLE; returns at the negedge inside cycle T+1.
  task automatic issue(input logic wr, input logic [1:0] sz, input logic sg,
                       input logic [63:0] a, input logic [63:0] wd);
    req_valid   = 1'b1;
    req_write   = wr;
    req_size    = sz;
    req_signed  = sg;
    req_address = a;
    req_wdata   = wd;
    @(posedge clock);
    @(negedge clock);
    req_valid = 1'b0;
  endtask

  task automatic load_chk(input string tag, input logic [1:0] sz, input logic sg,
                          input logic [63:0] a, input logic [63:0] exp);
    issue(1'b0, sz, sg, a, 64'h0);
    @(negedge clock);
    @(negedge clock);
    chk({tag, "_valid"}, 64'(resp_valid), 64'd1);
    chk({tag, "_fault"}, 64'(resp_fault), 64'd0);
    chk({tag, "_data"}, resp_data, exp);
    @(negedge clock);
  endtask

  task automatic fault_chk(input string tag, input logic wr, input logic [1:0] sz,
                           input logic [63:0] a);
    issue(wr, sz, 1'b0, a, 64'hFFFF_FFFF_FFFF_FFFF);
    chk({tag, "_valid"}, 64'(resp_valid), 64'd1);
    chk({tag, "_fault"}, 64'(resp_fault), 64'd1);
    chk({tag, "_data"}, resp_data, 64'd0);
    chk({tag, "_rd"}, 64'(mem_read), 64'd0);
    chk({tag, "_wr"}, 64'(mem_write), 64'd0);
    @(negedge clock);
    chk({tag, "_ready"}, 64'(req_ready), 64'd1);
  endtask

  initial begin
    reset_n     = 1'b0;
    req_valid   = 1'b0;
    req_write   = 1'b0;
    req_size    = 2'd0;
    req_signed  = 1'b0;
    req_address = 64'h0;
    req_wdata   = 64'h0;

    // Reset
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_ready", 64'(req_ready), 64'd1);
    chk("rst_resp_valid", 64'(resp_valid), 64'd0);
    chk("rst_mem_read", 64'(mem_read), 64'd0);
    chk("rst_mem_write", 64'(mem_write), 64'd0);
    chk("rst_resp_data", resp_data, 64'd0);
    reset_n = 1'b1;
    @(negedge clock);

    // Store D then load D
    issue(1'b1, 2'd3, 1'b0, 64'h10, 64'h1122_3344_5566_7788);
    chk("stD_wr", 64'(mem_write), 64'd1);
    chk("stD_rd", 64'(mem_read), 64'd0);
    chk("stD_addr", mem_address, 64'd2);
    chk("stD_wdata", mem_wdata, 64'h1122_3344_5566_7788);
    @(negedge clock);
    chk("stD_resp", 64'(resp_valid), 64'd1);
    chk("stD_data", resp_data, 64'd0);
    @(negedge clock);
    chk("stD_ready", 64'(req_ready), 64'd1);

    issue(1'b0, 2'd3, 1'b0, 64'h10, 64'h0);
    chk("ldD_rd", 64'(mem_read), 64'd1);
    chk("ldD_addr", mem_address, 64'd2);
    @(negedge clock);
    chk("ldD_early", 64'(resp_valid), 64'd0);
    @(negedge clock);
    chk("ldD_resp", 64'(resp_valid), 64'd1);
    chk("ldD_data", resp_data, 64'h1122_3344_5566_7788);
    @(negedge clock);

    // Store B (upper wdata bytes must be ignored)
    issue(1'b1, 2'd0, 1'b0, 64'h13, 64'h0123_4567_89AB_CDAB);
    chk("stB_rd", 64'(mem_read), 64'd1);
    chk("stB_wr1", 64'(mem_write), 64'd0);
    @(negedge clock);
    chk("stB_wr2", 64'(mem_write), 64'd0);
    @(negedge clock);
    chk("stB_wr3", 64'(mem_write), 64'd1);
    chk("stB_addr", mem_address, 64'd2);
    chk("stB_wdata", mem_wdata, 64'h1122_3344_AB66_7788);
    @(negedge clock);
    chk("stB_resp", 64'(resp_valid), 64'd1);
    @(negedge clock);

    // Loads with extension over 0x11223344AB667788
    load_chk("ldB_s", 2'd0, 1'b1, 64'h13, 64'hFFFF_FFFF_FFFF_FFAB);
    load_chk("ldB_u", 2'd0, 1'b0, 64'h13, 64'h0000_0000_0000_00AB);
    load_chk("ldW_s14", 2'd2, 1'b1, 64'h14, 64'h0000_0000_1122_3344);
    load_chk("ldW_s10", 2'd2, 1'b1, 64'h10, 64'hFFFF_FFFF_AB66_7788);
    load_chk("ldW_u10", 2'd2, 1'b0, 64'h10, 64'h0000_0000_AB66_7788);
    load_chk("ldH_s12", 2'd1, 1'b1, 64'h12, 64'hFFFF_FFFF_FFFF_AB66);
    load_chk("ldH_s16", 2'd1, 1'b1, 64'h16, 64'h0000_0000_0000_1122);
    load_chk("ldD_sgn", 2'd3, 1'b1, 64'h10, 64'h1122_3344_AB66_7788);

    // Misaligned accesses
    fault_chk("fltH11", 1'b0, 2'd1, 64'h11);
    fault_chk("fltW16", 1'b1, 2'd2, 64'h16);
    fault_chk("fltD14", 1'b0, 2'd3, 64'h14);

    // Reset during WAIT of a store H leaves memory untouched
    issue(1'b1, 2'd3, 1'b0, 64'h18, 64'hCAFE_BABE_DEAD_BEEF);
    @(negedge clock);
    @(negedge clock);
    wc0 = write_count;
    issue(1'b1, 2'd1, 1'b0, 64'h1A, 64'h5555);
    chk("abort_rd", 64'(mem_read), 64'd1);
    @(negedge clock);
    reset_n = 1'b0;
    @(negedge clock);
    chk("abort_wr", 64'(mem_write), 64'd0);
    chk("abort_ready", 64'(req_ready), 64'd1);
    chk("abort_resp", 64'(resp_valid), 64'd0);
    reset_n = 1'b1;
    @(negedge clock);
    @(negedge clock);
    chk("abort_wcount", 64'(write_count - wc0), 64'd0);
    load_chk("abort_word", 2'd3, 1'b0, 64'h18, 64'hCAFE_BABE_DEAD_BEEF);

    // Back-to-back loads with req_valid held high
    req_valid   = 1'b1;
    req_write   = 1'b0;
    req_size    = 2'd2;
    req_signed  = 1'b0;
    req_address = 64'h10;
    req_wdata   = 64'h0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clock);
      chk($sformatf("b2b_valid_%0d", k), 64'(resp_valid), 64'((k == 3) || (k == 7)));
      chk($sformatf("b2b_ready_%0d", k), 64'(req_ready), 64'((k == 4) || (k == 8)));
      if ((k == 3) || (k == 7))
        chk($sformatf("b2b_data_%0d", k), resp_data, 64'h0000_0000_AB66_7788);
    end
    req_valid = 1'b0;
    repeat (5) @(negedge clock);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
